mv_row_dot: RTL and testbench

Downstream consumer of the matrix row/column selector in the PE datapath. Latches one 16-element operand vector, then accepts one 256-bit matrix row per handshake from the selector, computes the signed dot product of each row with the latched vector through a 2-stage pipeline, and collects the N results into a packed result buffer. It drives the selector's `ready` input and raises `done` when all N rows have been reduced.

---
 rtl/pe_pkg.sv | 24 ++
 rtl/pe_adder_tree.sv | 21 ++
 rtl/mv_row_dot.sv | 133 +++++++++++++
 tb/tb_mv_row_dot.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared PE datapath constants, the mv_row_dot state encoding and the
// MSB-first operand element accessor used by the PE blocks.
package pe_pkg;

    localparam int PE_N  = 16;
    localparam int PE_DW = 16;
    localparam int PE_AW = 2*PE_DW + $clog2(PE_N);

    typedef enum logic [1:0] {
        MVD_IDLE,
        MVD_RUN,
        MVD_DRAIN,
        MVD_DONE
    } mvd_state_t;

    // Element 0 sits at the MSBs of the packed vector.
    function automatic logic signed [PE_DW-1:0] pe_elem(
        input logic [PE_N*PE_DW-1:0] vec,
        input int unsigned           i
    );
        return vec[(PE_N-i)*PE_DW-1 -: PE_DW];
    endfunction

endpackage

// File: rtl/pe_adder_tree.sv
// Combinational signed reduction of N packed IW-bit terms (term 0 at MSBs)
// to one OW-bit sum; zero latency, no flow control.
module pe_adder_tree #(
    parameter int N  = pe_pkg::PE_N,
    parameter int IW = 2*pe_pkg::PE_DW,
    parameter int OW = pe_pkg::PE_AW
) (
    input  logic [N*IW-1:0]        terms_i,
    output logic signed [OW-1:0]   sum_o
);

    // Each term is sign-extended to OW before summing, so OW >= IW+log2(N)
    // keeps the reduction exact.
    always_comb begin
        sum_o = '0;
        for (int i = 0; i < N; i++) begin
            sum_o = sum_o + OW'($signed(terms_i[(N-i)*IW-1 -: IW]));
        end
    end

endmodule

// File: rtl/mv_row_dot.sv
// Row-by-vector signed dot products into a packed result buffer; a row accepted at
// edge t lands in its slot at edge t+2. row_ready is high only in RUN, one row per cycle.
module mv_row_dot
    import pe_pkg::*;
#(
    parameter int N  = PE_N,
    parameter int DW = PE_DW,
    parameter int AW = 2*DW + $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [N*DW-1:0]   vec,
    input  logic [N*DW-1:0]   row_in,
    input  logic              row_valid,
    output logic              row_ready,
    output logic [N*AW-1:0]   result,
    output logic              busy,
    output logic              done
);

    localparam int IW = 2*DW;
    localparam int CW = $clog2(N) + 1;

    mvd_state_t          state_q;
    logic [N*DW-1:0]     vec_q;
    logic [CW-1:0]       rd_idx_q;
    logic [CW-1:0]       wr_idx_q;
    logic                row_ready_q;
    logic                busy_q;
    logic                done_q;
    logic [N*AW-1:0]     result_q;

    logic [N*IW-1:0]     prod_q;
    logic                s1_vld_q;
    logic signed [AW-1:0] sum_d;
    logic signed [AW-1:0] sum_q;
    logic                s2_vld_q;

    logic                accept;
    logic                last_wr;

    assign accept  = row_valid && row_ready_q;
    assign last_wr = s2_vld_q && (wr_idx_q == CW'(N-1));

    // S1: per-element signed products; operands are sign-extended before the multiply.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < N; i++) begin
                prod_q[(N-i)*IW-1 -: IW] <= IW'(pe_elem(row_in, i)) * IW'(pe_elem(vec_q, i));
            end
        end
    end

    pe_adder_tree #(
        .N  (N),
        .IW (IW),
        .OW (AW)
    ) u_tree (
        .terms_i (prod_q),
        .sum_o   (sum_d)
    );

    always_ff @(posedge clk) begin
        sum_q <= sum_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
        end else begin
            s1_vld_q <= accept;
            s2_vld_q <= s1_vld_q;
        end
    end

    // DONE is entered on the edge that writes the final slot, so done pulses right after it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= MVD_IDLE;
            vec_q       <= '0;
            rd_idx_q    <= '0;
            wr_idx_q    <= '0;
            row_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= '0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                rd_idx_q <= rd_idx_q + CW'(1);
            end
            if (s2_vld_q) begin
                result_q[(N-int'(wr_idx_q))*AW-1 -: AW] <= sum_q;
                wr_idx_q <= wr_idx_q + CW'(1);
            end
            case (state_q)
                MVD_IDLE, MVD_DONE: begin
                    if (start) begin
                        state_q     <= MVD_RUN;
                        vec_q       <= vec;
                        rd_idx_q    <= '0;
                        wr_idx_q    <= '0;
                        result_q    <= '0;
                        row_ready_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                MVD_RUN: begin
                    if (accept && (rd_idx_q == CW'(N-1))) begin
                        state_q     <= MVD_DRAIN;
                        row_ready_q <= 1'b0;
                    end
                end
                MVD_DRAIN: begin
                    if (last_wr) begin
                        state_q <= MVD_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= MVD_IDLE;
            endcase
        end
    end

    assign row_ready = row_ready_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;

endmodule

// File: tb/tb_mv_row_dot.sv
// Directed bench for mv_row_dot: expected dot products are queued when a pass
// is started and popped against the result slots once done pulses.
module tb_mv_row_dot;

    localparam int N  = 16;
    localparam int DW = 16;
    localparam int AW = 36;
    localparam int VW = N*DW;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [VW-1:0]   vec;
    logic [VW-1:0]   row_in;
    logic            row_valid;
    logic            row_ready;
    logic [N*AW-1:0] result;
    logic            busy;
    logic            done;

    logic [VW-1:0]        rows [N];
    logic signed [63:0]   exp_q [$];
    int                   errors = 0;
    int                   checks = 0;

    mv_row_dot #(.N(N), .DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .vec       (vec),
        .row_in    (row_in),
        .row_valid (row_valid),
        .row_ready (row_ready),
        .result    (result),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic signed [DW-1:0] el(input logic [VW-1:0] v, input int i);
        return v[VW-1-i*DW -: DW];
    endfunction

    function automatic logic signed [63:0] slot(input int r);
        logic signed [AW-1:0] s;
        s = result[(N-r)*AW-1 -: AW];
        return s;
    endfunction

    function automatic logic signed [63:0] dot(input logic [VW-1:0] v, input logic [VW-1:0] row);
        longint acc;
        acc = 0;
        for (int i = 0; i < N; i++) acc += longint'(el(row, i)) * longint'(el(v, i));
        return acc;
    endfunction

    function automatic logic [VW-1:0] rnd_vec();
        logic [VW-1:0] v;
        for (int i = 0; i < VW/32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic run_pass(input logic [VW-1:0] v, input string name, input bit gaps, input bit busy_start);
        int e;
        int r;
        bit acc;
        bit seen;
        for (int i = 0; i < N; i++) exp_q.push_back(dot(v, rows[i]));
        vec   = v;
        start = 1'b1;
        step;
        e     = 0;
        start = 1'b0;
        vec   = ~v;
        check({name, "_ready_after_start"}, row_ready, 1);
        check({name, "_busy_after_start"}, busy, 1);
        r = 0;
        while (r < N && e < 200) begin
            row_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            row_in    = row_valid ? rows[r] : rnd_vec();
            start     = busy_start && (r == 5);
            acc       = row_valid && row_ready;
            step;
            e++;
            start = 1'b0;
            if (acc) r++;
            if (!gaps && e == 2) check({name, "_slot0_before_latency"}, slot(0), 0);
            if (!gaps && e == 3) check({name, "_slot0_at_latency"}, slot(0), exp_q[0]);
        end
        check({name, "_rows_accepted"}, r, N);
        check({name, "_ready_low_after_last"}, row_ready, 0);
        // Keep offering junk during drain; it must be ignored.
        row_valid = 1'b1;
        row_in    = rnd_vec();
        seen      = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            step;
            e++;
            if (done === 1'b1) seen = 1'b1;
        end
        row_valid = 1'b0;
        check({name, "_done_seen"}, seen, 1);
        if (!gaps) check({name, "_done_edge"}, e, N+2);
        check({name, "_busy_low_at_done"}, busy, 0);
        for (int i = 0; i < N; i++) begin
            check($sformatf("%s_slot%0d", name, i), slot(i), exp_q.pop_front());
        end
        step;
        check({name, "_done_pulse_width"}, done, 0);
    endtask

    initial begin
        logic [VW-1:0] v;
        rst       = 1'b1;
        start     = 1'b0;
        vec       = '0;
        row_in    = '0;
        row_valid = 1'b0;
        step;
        step;
        rst = 1'b0;
        check("reset_row_ready", row_ready, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_result_zero", (result === '0), 1);

        // Identity rows: result r = vec[r] = r+1.
        for (int r = 0; r < N; r++) begin
            for (int i = 0; i < N; i++) begin
                rows[r][VW-1-i*DW -: DW] = (i == r) ? 16'd1 : 16'd0;
                v[VW-1-i*DW -: DW]       = 16'(i + 1);
            end
        end
        run_pass(v, "identity", 1'b0, 1'b0);
        check("identity_slot15_const", slot(15), 16);

        // Extreme negative operands.
        v = {N{16'h8000}};
        for (int r = 0; r < N; r++) rows[r] = {N{16'h8000}};
        run_pass(v, "extreme", 1'b0, 1'b0);
        check("extreme_slot0_const", slot(0), 64'sd17179869184);

        // Mixed signs: vec all ones, row r all (r-8).
        v = {N{16'h0001}};
        for (int r = 0; r < N; r++) rows[r] = {N{16'(r - 8)}};
        run_pass(v, "mixed", 1'b0, 1'b0);
        check("mixed_slot0_const", slot(0), -128);
        check("mixed_slot15_const", slot(15), 112);

        // Random data with random bubbles.
        for (int r = 0; r < N; r++) rows[r] = rnd_vec();
        v = rnd_vec();
        run_pass(v, "backpressure", 1'b1, 1'b0);

        // start with a different vec mid-RUN must be ignored.
        run_pass(v, "start_busy", 1'b0, 1'b1);

        // Reset after 7 accepted rows, with start asserted alongside.
        vec   = v;
        start = 1'b1;
        step;
        start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            row_valid = 1'b1;
            row_in    = rows[k];
            step;
        end
        rst   = 1'b1;
        start = 1'b1;
        step;
        rst       = 1'b0;
        start     = 1'b0;
        check("midrst_row_ready", row_ready, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_result_zero", (result === '0), 1);
        step;
        check("idle_ignores_rows", row_ready, 0);
        row_valid = 1'b0;
        for (int r = 0; r < N; r++) rows[r] = rnd_vec();
        run_pass(rnd_vec(), "after_reset", 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
